// File: rtl/rv32_mod_decode_queue.sv
// rv32_mod_decode_queue
//
// Buffered decode stage between fetch and execute. Each fetched word is
// decoded as it is accepted, and the decoded bundle is stored in a
// DEPTH-entry circular FIFO. The head entry is presented to execute.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   flush             synchronous queue clear on redirect (highest priority)
//   priviledge        current privilege level, sampled at enqueue
//   in_valid/in_ready fetch-side handshake (in_ready ignores in_valid)
//   in_instruction    fetched 32-bit word
//   in_pc             PC of in_instruction
//   out_valid/out_ready execute-side handshake
//   out_pc, out_instruction, out_rs1/rs2/rd, out_format {r,i,s,b,u,j},
//   out_func {is_jalr,is_lui,alt,funct3}, out_is_mem_or_io, out_is_system,
//   out_sys_jump_to_m, out_sys_ret_from_priv, out_error   head entry payload
//   occupancy         number of valid entries
//
// Build option:
//   DECODE_QUEUE_BYPASS_EN  when defined, an empty queue forwards the
//                           decode of in_* combinationally to out_*.
//                           It is undefined by default (one-cycle minimum latency).

module rv32_mod_decode_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [1:0]                 priviledge,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instruction,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [31:0]                out_instruction,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [5:0]                 out_format,
    output logic [5:0]                 out_func,
    output logic                       out_is_mem_or_io,
    output logic                       out_is_system,
    output logic                       out_sys_jump_to_m,
    output logic                       out_sys_ret_from_priv,
    output logic                       out_error,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;
    localparam logic [31:0] WORD_WFI    = 32'h1050_0073;
    localparam logic [31:0] WORD_MRET   = 32'h3020_0073;

    // Major opcode classes, keyed on instruction[6:2]
    typedef enum logic [4:0] {
        OPC_LOAD      = 5'b00000,
        OPC_MISC_MEM  = 5'b00011,
        OPC_OP_IMM    = 5'b00100,
        OPC_AUIPC     = 5'b00101,
        OPC_OP_IMM_32 = 5'b00110,
        OPC_STORE     = 5'b01000,
        OPC_OP        = 5'b01100,
        OPC_LUI       = 5'b01101,
        OPC_BRANCH    = 5'b11000,
        OPC_JALR      = 5'b11001,
        OPC_JAL       = 5'b11011,
        OPC_SYSTEM    = 5'b11100
    } opcode_e;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         instruction;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [5:0]          format;
        logic [5:0]          func;
        logic                is_mem_or_io;
        logic                is_system;
        logic                sys_jump_to_m;
        logic                sys_ret_from_priv;
        logic                error;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    entry_t     dec;
    logic       fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
    logic       is_jalr, is_lui, is_mem, is_sys, known_opcode;
    logic       alt;
    logic [2:0] funct3;
    logic       is_ecall_ebreak, is_mret_m, sys_legal;

    always_comb begin
        fmt_r        = 1'b0;
        fmt_i        = 1'b0;
        fmt_s        = 1'b0;
        fmt_b        = 1'b0;
        fmt_u        = 1'b0;
        fmt_j        = 1'b0;
        is_jalr      = 1'b0;
        is_lui       = 1'b0;
        is_mem       = 1'b0;
        is_sys       = 1'b0;
        known_opcode = 1'b1;

        case (in_instruction[6:2])
            OPC_LOAD:      begin fmt_i = 1'b1; is_mem = 1'b1; end
            OPC_MISC_MEM:  ;
            OPC_OP_IMM:    fmt_i = 1'b1;
            OPC_OP_IMM_32: fmt_i = 1'b1;
            OPC_AUIPC:     fmt_u = 1'b1;
            OPC_LUI:       begin fmt_u = 1'b1; is_lui = 1'b1; end
            OPC_STORE:     begin fmt_s = 1'b1; is_mem = 1'b1; end
            OPC_OP:        fmt_r = 1'b1;
            OPC_BRANCH:    begin fmt_s = 1'b1; fmt_b = 1'b1; end
            OPC_JALR:      begin fmt_i = 1'b1; is_jalr = 1'b1; end
            OPC_JAL:       begin fmt_u = 1'b1; fmt_j = 1'b1; end
            OPC_SYSTEM:    begin fmt_i = 1'b1; is_sys = 1'b1; end
            default:       known_opcode = 1'b0;
        endcase

        funct3 = in_instruction[14:12];
        // funct7 only matters for R-type and the I-type shift-right group
        alt    = in_instruction[30] & (fmt_r | (fmt_i & (funct3 == 3'b101)));

        is_ecall_ebreak = (in_instruction == WORD_ECALL) || (in_instruction == WORD_EBREAK);
        is_mret_m       = (in_instruction == WORD_MRET) && (priviledge == 2'b11);
        // funct3 != 0 is the CSR group, always legal
        sys_legal       = (funct3 != 3'b000) || is_ecall_ebreak || is_mret_m ||
                          (in_instruction == WORD_WFI);

        dec                   = '0;
        dec.pc                = in_pc;
        dec.instruction       = in_instruction;
        dec.rs1               = fmt_u ? 5'd0 : in_instruction[19:15];
        dec.rs2               = fmt_u ? 5'd0 : in_instruction[24:20];
        dec.rd                = fmt_s ? 5'd0 : in_instruction[11:7];
        dec.format            = {fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j};
        dec.func              = {is_jalr, is_lui, alt, funct3};
        dec.is_mem_or_io      = is_mem;
        dec.is_system         = is_sys;
        dec.sys_jump_to_m     = is_ecall_ebreak;
        dec.sys_ret_from_priv = is_mret_m;
        dec.error             = (in_instruction[1:0] != 2'b11) || !known_opcode ||
                                (is_sys && !sys_legal);
    end

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    entry_t             storage [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   occ_q;
    logic               queue_valid;
    logic               push_q, pop_q;
    entry_t             head;

    assign queue_valid = (occ_q != '0);
    assign in_ready    = (occ_q != OCC_W'(DEPTH));
    assign pop_q       = queue_valid && out_ready && !flush;
    assign head        = storage[rd_ptr];

`ifdef DECODE_QUEUE_BYPASS_EN
    logic bypass;

    // An empty queue forwards the fresh decode; if execute takes it in the
    // same cycle the word never touches storage.
    assign bypass    = !queue_valid && in_valid && !flush;
    assign out_valid = queue_valid || bypass;
    assign push_q    = in_valid && in_ready && !flush && !(bypass && out_ready);

    entry_t out_entry;
    assign out_entry = bypass ? dec : head;
`else
    assign out_valid = queue_valid;
    assign push_q    = in_valid && in_ready && !flush;

    entry_t out_entry;
    assign out_entry = head;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push_q) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_q, pop_q})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage is cleared only by reset; flush just rewinds the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (push_q) begin
            storage[wr_ptr] <= dec;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign occupancy             = occ_q;
    assign out_pc                = out_entry.pc;
    assign out_instruction       = out_entry.instruction;
    assign out_rs1               = out_entry.rs1;
    assign out_rs2               = out_entry.rs2;
    assign out_rd                = out_entry.rd;
    assign out_format            = out_entry.format;
    assign out_func              = out_entry.func;
    assign out_is_mem_or_io      = out_entry.is_mem_or_io;
    assign out_is_system         = out_entry.is_system;
    assign out_sys_jump_to_m     = out_entry.sys_jump_to_m;
    assign out_sys_ret_from_priv = out_entry.sys_ret_from_priv;
    assign out_error             = out_entry.error;

endmodule

// File: tb/tb_rv32_mod_decode_queue.sv
// Self-checking bench for rv32_mod_decode_queue (default build).
// Decode table vectors, hand-written multi-cycle sequences, and a random
// phase compared against a queue-based reference model.

module tb_rv32_mod_decode_queue;

    localparam int DEPTH    = 4;
    localparam int PC_WIDTH = 32;
    localparam int OCC_W    = $clog2(DEPTH+1);

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [1:0]          priviledge;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instruction;
    logic [PC_WIDTH-1:0] in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [31:0]         out_instruction;
    logic [4:0]          out_rs1, out_rs2, out_rd;
    logic [5:0]          out_format, out_func;
    logic                out_is_mem_or_io, out_is_system;
    logic                out_sys_jump_to_m, out_sys_ret_from_priv, out_error;
    logic [OCC_W-1:0]    occupancy;

    rv32_mod_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush                 (flush),
        .priviledge            (priviledge),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_instruction        (in_instruction),
        .in_pc                 (in_pc),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_pc                (out_pc),
        .out_instruction       (out_instruction),
        .out_rs1               (out_rs1),
        .out_rs2               (out_rs2),
        .out_rd                (out_rd),
        .out_format            (out_format),
        .out_func              (out_func),
        .out_is_mem_or_io      (out_is_mem_or_io),
        .out_is_system         (out_is_system),
        .out_sys_jump_to_m     (out_sys_jump_to_m),
        .out_sys_ret_from_priv (out_sys_ret_from_priv),
        .out_error             (out_error),
        .occupancy             (occupancy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic [5:0]  fmt, func;
        logic [4:0]  flags; // {mem, sys, jump_to_m, ret_from_priv, error}
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  priv;
        logic [4:0]  rs1, rs2, rd;
        logic [5:0]  fmt, func;
        logic [4:0]  flags;
    } vec_t;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input exp_t e);
        check({tag, ".valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, ".pc"},    128'(out_pc), 128'(e.pc));
        check({tag, ".instr"}, 128'(out_instruction), 128'(e.instr));
        check({tag, ".regs"},  128'({out_rs1, out_rs2, out_rd}), 128'({e.rs1, e.rs2, e.rd}));
        check({tag, ".fmt"},   128'(out_format), 128'(e.fmt));
        check({tag, ".func"},  128'(out_func), 128'(e.func));
        check({tag, ".flags"}, 128'({out_is_mem_or_io, out_is_system, out_sys_jump_to_m,
                                     out_sys_ret_from_priv, out_error}), 128'(e.flags));
    endtask

    // Reference decode built directly from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [1:0] priv,
                                        input logic [31:0] pc);
        exp_t       e;
        logic [6:0] op;
        bit         r, i, s, b, u, j, known, mem, sys, jm, ret, err, alt;
        op    = {w[6:2], 2'b11};
        r     = (op == 7'h33);
        i     = op inside {7'h03, 7'h13, 7'h1B, 7'h67, 7'h73};
        s     = op inside {7'h23, 7'h63};
        b     = (op == 7'h63);
        u     = op inside {7'h17, 7'h37, 7'h6F};
        j     = (op == 7'h6F);
        known = r || i || s || u || (op == 7'h0F);
        mem   = op inside {7'h03, 7'h23};
        sys   = (op == 7'h73);
        jm    = (w == 32'h0000_0073) || (w == 32'h0010_0073);
        ret   = (w == 32'h3020_0073) && (priv == 2'd3);
        alt   = w[30] && (r || (i && w[14:12] == 3'd5));
        err   = (w[1:0] != 2'b11) || !known ||
                (sys && w[14:12] == 3'd0 && !(jm || ret || w == 32'h1050_0073));
        e.pc    = pc;
        e.instr = w;
        e.rs1   = u ? 5'd0 : w[19:15];
        e.rs2   = u ? 5'd0 : w[24:20];
        e.rd    = s ? 5'd0 : w[11:7];
        e.fmt   = {r, i, s, b, u, j};
        e.func  = {op == 7'h67, op == 7'h37, alt, w[14:12]};
        e.flags = {mem, sys, jm, ret, err};
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: begin
                case ($urandom_range(0, 11))
                    0:  w[6:0] = 7'h03;
                    1:  w[6:0] = 7'h0F;
                    2:  w[6:0] = 7'h13;
                    3:  w[6:0] = 7'h17;
                    4:  w[6:0] = 7'h1B;
                    5:  w[6:0] = 7'h23;
                    6:  w[6:0] = 7'h33;
                    7:  w[6:0] = 7'h37;
                    8:  w[6:0] = 7'h63;
                    9:  w[6:0] = 7'h67;
                    10: w[6:0] = 7'h6F;
                    default: w[6:0] = 7'h73;
                endcase
            end
            6, 7: begin
                case ($urandom_range(0, 4))
                    0: w = 32'h0000_0073;
                    1: w = 32'h0010_0073;
                    2: w = 32'h1050_0073;
                    3: w = 32'h3020_0073;
                    default: w = {w[31:15], 3'b000, w[11:7], 7'h73};
                endcase
            end
            default: ;
        endcase
        return w;
    endfunction

    function automatic vec_t mkv(input logic [31:0] instr, input logic [1:0] priv,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [5:0] fmt, input logic [5:0] func,
                                 input logic [4:0] flags);
        vec_t v;
        v.instr = instr; v.priv = priv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.fmt = fmt; v.func = func; v.flags = flags;
        return v;
    endfunction

    vec_t tbl[$];
    exp_t model_q[$];

    initial begin
        exp_t e;
        int   sz;
        logic [31:0] w;

        // flags = {mem, sys, jump_to_m, ret_from_priv, error}
        tbl.push_back(mkv(32'h0050_0093, 2'd0, 5'd0, 5'd5, 5'd1, 6'b010000, 6'b000000, 5'b00000));
        tbl.push_back(mkv(32'h0010_0073, 2'd0, 5'd0, 5'd1, 5'd0, 6'b010000, 6'b000000, 5'b01100));
        tbl.push_back(mkv(32'h3020_0073, 2'd0, 5'd0, 5'd2, 5'd0, 6'b010000, 6'b000000, 5'b01001));
        tbl.push_back(mkv(32'h3020_0073, 2'd3, 5'd0, 5'd2, 5'd0, 6'b010000, 6'b000000, 5'b01010));
        tbl.push_back(mkv(32'h0000_007F, 2'd0, 5'd0, 5'd0, 5'd0, 6'b000000, 6'b000000, 5'b00001));
        tbl.push_back(mkv(32'h0000_0001, 2'd0, 5'd0, 5'd0, 5'd0, 6'b010000, 6'b000000, 5'b10001));
        tbl.push_back(mkv(32'h4020_5093, 2'd0, 5'd0, 5'd2, 5'd1, 6'b010000, 6'b001101, 5'b00000));
        tbl.push_back(mkv(32'h0000_0073, 2'd3, 5'd0, 5'd0, 5'd0, 6'b010000, 6'b000000, 5'b01100));
        tbl.push_back(mkv(32'h1050_0073, 2'd0, 5'd0, 5'd5, 5'd0, 6'b010000, 6'b000000, 5'b01000));
        tbl.push_back(mkv(32'h3000_20F3, 2'd0, 5'd0, 5'd0, 5'd1, 6'b010000, 6'b000010, 5'b01000));
        tbl.push_back(mkv(32'h0020_0073, 2'd3, 5'd0, 5'd2, 5'd0, 6'b010000, 6'b000000, 5'b01001));
        tbl.push_back(mkv(32'h0020_81B3, 2'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 6'b000000, 5'b00000));
        tbl.push_back(mkv(32'h4020_81B3, 2'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 6'b001000, 5'b00000));
        tbl.push_back(mkv(32'h1234_02B7, 2'd0, 5'd0, 5'd0, 5'd5, 6'b000010, 6'b010000, 5'b00000));
        tbl.push_back(mkv(32'h0000_00EF, 2'd0, 5'd0, 5'd0, 5'd1, 6'b000011, 6'b000000, 5'b00000));
        tbl.push_back(mkv(32'h0000_8067, 2'd0, 5'd1, 5'd0, 5'd0, 6'b010000, 6'b100000, 5'b00000));
        tbl.push_back(mkv(32'h0020_A223, 2'd0, 5'd1, 5'd2, 5'd0, 6'b001000, 6'b000010, 5'b10000));
        tbl.push_back(mkv(32'h0020_8463, 2'd0, 5'd1, 5'd2, 5'd0, 6'b001100, 6'b000000, 5'b00000));
        tbl.push_back(mkv(32'h0000_A283, 2'd0, 5'd1, 5'd0, 5'd5, 6'b010000, 6'b000010, 5'b10000));
        tbl.push_back(mkv(32'h0000_000F, 2'd0, 5'd0, 5'd0, 5'd0, 6'b000000, 6'b000000, 5'b00000));
        tbl.push_back(mkv(32'h0000_0097, 2'd0, 5'd0, 5'd0, 5'd1, 6'b000010, 6'b000000, 5'b00000));
        tbl.push_back(mkv(32'h0010_809B, 2'd0, 5'd1, 5'd1, 5'd1, 6'b010000, 6'b000000, 5'b00000));
        tbl.push_back(mkv(32'h4000_0093, 2'd0, 5'd0, 5'd0, 5'd1, 6'b010000, 6'b000000, 5'b00000));

        rst = 1'b1; flush = 1'b0; priviledge = 2'd0; in_valid = 1'b0;
        in_instruction = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst.out_valid", 128'(out_valid), 128'(0));
        check("rst.in_ready",  128'(in_ready), 128'(1));
        check("rst.occupancy", 128'(occupancy), 128'(0));
        check("rst.payload",   128'({out_pc, out_instruction, out_format, out_func, out_error}), 128'(0));

        // First transaction: one-cycle latency
        in_instruction = 32'h0050_0093; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        e = '{pc: 32'h100, instr: 32'h0050_0093, rs1: 5'd0, rs2: 5'd5, rd: 5'd1,
              fmt: 6'b010000, func: 6'b000000, flags: 5'b00000};
        check_head("first", e);
        check("first.occupancy", 128'(occupancy), 128'(1));
        step();
        check("first.drained_occ",   128'(occupancy), 128'(0));
        check("first.drained_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b0;

        // Decode table: enqueue, inspect head, dequeue
        for (int k = 0; k < tbl.size(); k++) begin
            in_instruction = tbl[k].instr; priviledge = tbl[k].priv;
            in_pc = 32'h1000 + 32'(k * 4); in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            e = '{pc: 32'h1000 + 32'(k * 4), instr: tbl[k].instr, rs1: tbl[k].rs1,
                  rs2: tbl[k].rs2, rd: tbl[k].rd, fmt: tbl[k].fmt, func: tbl[k].func,
                  flags: tbl[k].flags};
            check_head($sformatf("tbl%0d", k), e);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check($sformatf("tbl%0d.occ", k), 128'(occupancy), 128'(0));
        end
        priviledge = 2'd0;

        // Back-pressure: five words against a full queue, then drain
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_instruction = 32'h13 | (32'(k) << 7); in_pc = 32'h200 + 32'(4 * k);
            step();
        end
        in_instruction = 32'h13 | (32'd5 << 7); in_pc = 32'h214;
        check("bp.full_occ",   128'(occupancy), 128'(4));
        check("bp.full_ready", 128'(in_ready), 128'(0));
        check("bp.full_head",  128'(out_pc), 128'(32'h204));
        step();
        check("bp.hold_head",  128'(out_pc), 128'(32'h204));
        out_ready = 1'b1;
        step();
        check("bp.d1_occ",   128'(occupancy), 128'(3));
        check("bp.d1_head",  128'(out_pc), 128'(32'h208));
        check("bp.d1_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        check("bp.d2_occ",  128'(occupancy), 128'(3));
        check("bp.d2_head", 128'(out_pc), 128'(32'h20C));
        step();
        check("bp.d3_head", 128'(out_pc), 128'(32'h210));
        step();
        check("bp.d4_head",  128'(out_pc), 128'(32'h214));
        check("bp.d4_instr", 128'(out_instruction), 128'(32'h293));
        step();
        check("bp.empty_valid", 128'(out_valid), 128'(0));
        check("bp.empty_occ",   128'(occupancy), 128'(0));
        out_ready = 1'b0;

        // Flush with a concurrent enqueue
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instruction = 32'h0000_0013; in_pc = 32'h300 + 32'(4 * k);
            step();
        end
        check("fl.pre_occ", 128'(occupancy), 128'(3));
        flush = 1'b1; in_instruction = 32'h0020_81B3; in_pc = 32'h3F0;
        step();
        flush = 1'b0;
        check("fl.occ",   128'(occupancy), 128'(0));
        check("fl.valid", 128'(out_valid), 128'(0));
        check("fl.ready", 128'(in_ready), 128'(1));
        in_instruction = 32'h0000_00EF; in_pc = 32'h400;
        step();
        in_valid = 1'b0;
        check("fl.next_occ",  128'(occupancy), 128'(1));
        check("fl.next_head", 128'(out_pc), 128'(32'h400));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        in_instruction = 32'h0020_81B3; in_pc = 32'h500; step();
        in_instruction = 32'h0020_A223; in_pc = 32'h504; step();
        in_valid = 1'b0;
        check("ar.pre_occ", 128'(occupancy), 128'(2));
        #3 rst = 1'b1;
        #1;
        check("ar.valid", 128'(out_valid), 128'(0));
        check("ar.occ",   128'(occupancy), 128'(0));
        check("ar.payload", 128'({out_pc, out_instruction, out_rs1, out_rs2, out_rd,
                                  out_format, out_func, out_is_mem_or_io, out_is_system,
                                  out_sys_jump_to_m, out_sys_ret_from_priv, out_error}), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        check("ar.release_ready", 128'(in_ready), 128'(1));

        // Pointer wrap with simultaneous enqueue/dequeue at occupancy 1
        in_instruction = 32'h0000_0013; in_pc = 32'h600; in_valid = 1'b1;
        step();
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            in_instruction = 32'h13 | (32'(k) << 7); in_pc = 32'h600 + 32'(4 * k);
            step();
            check($sformatf("wrap%0d.occ", k),  128'(occupancy), 128'(1));
            check($sformatf("wrap%0d.head", k), 128'({out_pc, out_rd}), 128'({32'h600 + 32'(4 * k), 5'(k)}));
        end
        in_valid = 1'b0;
        step();
        check("wrap.end_occ", 128'(occupancy), 128'(0));
        out_ready = 1'b0;

        // Random traffic against the reference queue model
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            check("rnd.occ",       128'(occupancy), 128'(model_q.size()));
            check("rnd.out_valid", 128'(out_valid), 128'(model_q.size() != 0));
            check("rnd.in_ready",  128'(in_ready), 128'(model_q.size() != DEPTH));
            if (model_q.size() != 0) begin
                e = model_q[0];
                check("rnd.head",
                      128'({out_pc, out_instruction, out_rs1, out_rs2, out_rd, out_format, out_func,
                            out_is_mem_or_io, out_is_system, out_sys_jump_to_m,
                            out_sys_ret_from_priv, out_error}),
                      128'({e.pc, e.instr, e.rs1, e.rs2, e.rd, e.fmt, e.func, e.flags}));
            end
            flush      = ($urandom_range(0, 24) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 1) != 0);
            priviledge = 2'($urandom_range(0, 3));
            w = rand_word();
            in_instruction = w;
            in_pc = $urandom;
            sz = model_q.size();
            if (flush) begin
                model_q.delete();
            end else begin
                if (out_ready && sz != 0) void'(model_q.pop_front());
                if (in_valid && sz != DEPTH) model_q.push_back(ref_decode(w, priviledge, in_pc));
            end
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
